vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//  Raster timing generator for the text-mode VGA controller. Produces hsync/vsync,
//  display-enable and pixel/character-cell coordinates from free-running H/V counters.
//  It is the source of the vertical sync consumed by the cursor-blink logic, and it
//  drives the glyph fetch (col/row/glyph line) in the character pipeline.
// PARAMETERS
//  H_VIS 640 visible pixels/line;  H_FP 16;  H_SYNC 96;  H_BP 48   (H_TOTAL = 800)
//  V_VIS 480 visible lines/frame;  V_FP 10;  V_SYNC 2;   V_BP 33   (V_TOTAL = 525)
//  HS_POL 0   sync active level of o_hs (0 = active-low, as standard 640x480@60)
//  VS_POL 0   sync active level of o_vs
//  FONT_W_LOG2 3   glyph width  = 8 px
//  FONT_H_LOG2 4   glyph height = 16 lines
// PORTS
//  i_clk        in   1   system clock
//  i_rst_h      in   1   synchronous reset, active-high
//  i_pix_en_h   in   1   pixel strobe; counters and outputs advance only when 1
//  o_hs         out  1   horizontal sync, level per HS_POL
//  o_vs         out  1   vertical sync, level per VS_POL
//  o_de_h       out  1   display enable (visible-area pixel)
//  o_x          out  10  horizontal position, 0..H_TOTAL-1
//  o_y          out  10  vertical position, 0..V_TOTAL-1
//  o_col        out  7   character column = x >> FONT_W_LOG2
//  o_row        out  6   character row    = y >> FONT_H_LOG2
//  o_glyph_x    out  3   pixel within glyph = x[FONT_W_LOG2-1:0]
//  o_glyph_y    out  4   line within glyph  = y[FONT_H_LOG2-1:0]
//  o_line_h     out  1   1-clk pulse: first pixel of every line (x == 0)
//  o_frame_h    out  1   1-clk pulse: first pixel of frame (x == 0, y == 0)
// BEHAVIOUR
//  - Counters h_cnt and v_cnt advance only on clocks with i_pix_en_h = 1.
//    h_cnt wraps H_TOTAL-1 -> 0; v_cnt increments on that wrap and itself wraps
//    V_TOTAL-1 -> 0. i_pix_en_h = 0 freezes all state and all level outputs.
//  - Output registers load, on each pix_en clock, the decode of the counter value held
//    before that edge. Latency: 1 pix_en clock, counter -> outputs.
//    All outputs therefore describe the same pixel in the same cycle.
//  - Decode (h = h_cnt, v = v_cnt):
//    de = (h < H_VIS) && (v < V_VIS).
//    hs active for H_VIS+H_FP <= h < H_VIS+H_FP+H_SYNC (656..751).
//    vs active for V_VIS+V_FP <= v < V_VIS+V_FP+V_SYNC (lines 490..491), all pixels of those lines.
//  - o_x/o_y/o_col/o_row/o_glyph_* track counters in blanking too;
//    they are meaningful for fetch only when o_de_h = 1.
//  - o_line_h, o_frame_h: high for exactly one i_clk cycle (the pix_en clock that loads
//    x == 0); cleared on the next clock even if i_pix_en_h stays 0.
//  - Reset (any time, incl. mid-frame), next clock: h_cnt = v_cnt = 0; o_hs, o_vs at
//    inactive level; o_de_h = 0; o_x = o_y = col = row = glyph = 0; pulses = 0.
//    The first pix_en clock after reset release presents (0,0) with
//    o_line_h = o_frame_h = 1 and o_de_h = 1.
//  - Reset has priority over i_pix_en_h. All arithmetic is unsigned;
//    widths are sized for H_TOTAL, V_TOTAL <= 1024.
// STRUCTURE
//  - Package vga_timing_pkg: default 640x480@60 timing constants, H_TOTAL/V_TOTAL,
//    coordinate widths, font size constants (shared with the char fetch and the cursor logic).
//  - One sub-module, vga_axis_counter (VIS/FP/SYNC/BP params; inc-enable in;
//    count, wrap, active, sync out). It is instantiated twice: H, and V enabled by the H wrap.
//    The top level holds only the output register stage and the col/row slicing.
// TESTING
//  1. Reset, pix_en = 1 every clk -> first clk: x = 0, y = 0, de = 1, line = frame = 1,
//     hs = vs = 1 (inactive).
//  2. One line -> de high for 640 pix, hs low at exactly x = 656..751 (96 pix),
//     o_line_h period 800 pix.
//  3. Full frame -> o_frame_h period 420000 pix; vs low for 1600 pix, y = 490..491;
//     de never high for y >= 480.
//  4. At x = 639, y = 479 -> col = 79, row = 29, glyph_x = 7, glyph_y = 15, de = 1;
//     next pix x = 640 -> de = 0.
//  5. pix_en toggled 1-of-4 clocks -> timings scale x4; outputs stable on gaps;
//     pulses exactly 1 clk wide.
//  6. Reset asserted at x = 700, y = 490 (hs, vs active) -> next clk: hs = vs = 1,
//     de = 0, x = y = 0; restart as in test 1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Raster timing constants for the text-mode VGA controller.
// Shared by the sync generator, the char fetch and the cursor logic.
package vga_timing_pkg;

  localparam int H_VIS  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VIS  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int CW          = 10;
  localparam int FONT_W_LOG2 = 3;
  localparam int FONT_H_LOG2 = 4;
  localparam int COL_W       = CW - FONT_W_LOG2;
  localparam int ROW_W       = CW - FONT_H_LOG2;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: free-running position counter with
// visible-area and sync-window decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VIS  = H_VIS,
  parameter int FP   = H_FP,
  parameter int SYNC = H_SYNC,
  parameter int BP   = H_BP,
  parameter int W    = CW
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o,
  output logic         active_o,
  output logic         sync_o
);

  localparam logic [W-1:0] LAST = W'(VIS + FP + SYNC + BP - 1);
  localparam logic [W-1:0] VEND = W'(VIS);
  localparam logic [W-1:0] SBEG = W'(VIS + FP);
  localparam logic [W-1:0] SEND = W'(VIS + FP + SYNC);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         last;

  assign last = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o  = cnt_q;
  assign wrap_o   = inc_i && last;
  assign active_o = (cnt_q < VEND);
  assign sync_o   = (cnt_q >= SBEG) && (cnt_q < SEND);

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: H/V counters plus one registered
// output stage so every output describes the same pixel.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VIS_P  = H_VIS,
  parameter int H_FP_P   = H_FP,
  parameter int H_SYNC_P = H_SYNC,
  parameter int H_BP_P   = H_BP,
  parameter int V_VIS_P  = V_VIS,
  parameter int V_FP_P   = V_FP,
  parameter int V_SYNC_P = V_SYNC,
  parameter int V_BP_P   = V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_h,
  input  logic                   i_pix_en_h,
  output logic                   o_hs,
  output logic                   o_vs,
  output logic                   o_de_h,
  output logic [CW-1:0]          o_x,
  output logic [CW-1:0]          o_y,
  output logic [COL_W-1:0]       o_col,
  output logic [ROW_W-1:0]       o_row,
  output logic [FONT_W_LOG2-1:0] o_glyph_x,
  output logic [FONT_H_LOG2-1:0] o_glyph_y,
  output logic                   o_line_h,
  output logic                   o_frame_h
);

  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap;
  logic          h_act, v_act;
  logic          h_sync, v_sync;

  vga_axis_counter #(
    .VIS(H_VIS_P), .FP(H_FP_P), .SYNC(H_SYNC_P), .BP(H_BP_P), .W(CW)
  ) u_h (
    .clk_i   (i_clk),
    .rst_i   (i_rst_h),
    .inc_i   (i_pix_en_h),
    .count_o (h_cnt),
    .wrap_o  (h_wrap),
    .active_o(h_act),
    .sync_o  (h_sync)
  );

  vga_axis_counter #(
    .VIS(V_VIS_P), .FP(V_FP_P), .SYNC(V_SYNC_P), .BP(V_BP_P), .W(CW)
  ) u_v (
    .clk_i   (i_clk),
    .rst_i   (i_rst_h),
    .inc_i   (h_wrap),
    .count_o (v_cnt),
    .wrap_o  (),
    .active_o(v_act),
    .sync_o  (v_sync)
  );

  logic          hs_q, vs_q, de_q;
  logic          line_q, frame_q;
  logic [CW-1:0] x_q, y_q;

  always_ff @(posedge i_clk) begin
    if (i_rst_h) begin
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      // pulses self-clear on gap clocks
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      if (i_pix_en_h) begin
        hs_q    <= h_sync ? HS_POL : ~HS_POL;
        vs_q    <= v_sync ? VS_POL : ~VS_POL;
        de_q    <= h_act && v_act;
        x_q     <= h_cnt;
        y_q     <= v_cnt;
        line_q  <= (h_cnt == '0);
        frame_q <= (h_cnt == '0) && (v_cnt == '0);
      end
    end
  end

  assign o_hs      = hs_q;
  assign o_vs      = vs_q;
  assign o_de_h    = de_q;
  assign o_x       = x_q;
  assign o_y       = y_q;
  assign o_col     = x_q[CW-1:FONT_W_LOG2];
  assign o_row     = y_q[CW-1:FONT_H_LOG2];
  assign o_glyph_x = x_q[FONT_W_LOG2-1:0];
  assign o_glyph_y = y_q[FONT_H_LOG2-1:0];
  assign o_line_h  = line_q;
  assign o_frame_h = frame_q;

endmodule
